// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider: N_WIDTH-bit dividend by D_WIDTH-bit divisor,
// one quotient bit per clock, valid/ready handshake on both operand and result sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one restoring-division iteration per clock (zero divisor resolves in one pass)
// DONE  | result presented with out_valid, held until out_ready
module div_seq #(
    parameter int N_WIDTH = 36,
    parameter int D_WIDTH = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remainder,
    output logic               div_by_zero
);

    localparam int CW = $clog2(N_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic [N_WIDTH-1:0] dvd_q;      // dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [D_WIDTH-1:0] dsr_q;
    logic [D_WIDTH:0]   rem_q;
    logic [CW-1:0]      cnt_q;
    logic               dz_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [N_WIDTH-1:0] quotient_q;
    logic [D_WIDTH-1:0] remainder_q;
    logic               div_by_zero_q;

    logic [D_WIDTH:0]   shift_rem;
    logic [D_WIDTH+1:0] trial;
    logic               qbit;
    logic [D_WIDTH:0]   rem_d;
    logic [N_WIDTH-1:0] quo_d;

    always_comb begin
        shift_rem = {rem_q[D_WIDTH-1:0], dvd_q[N_WIDTH-1]};
        trial     = {1'b0, shift_rem} - {2'b00, dsr_q};
        qbit      = ~trial[D_WIDTH+1];
        rem_d     = qbit ? trial[D_WIDTH:0] : shift_rem;
        quo_d     = {dvd_q[N_WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dvd_q         <= '0;
            dsr_q         <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            dz_q          <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        dvd_q      <= dividend;
                        dsr_q      <= divisor;
                        rem_q      <= '0;
                        cnt_q      <= CW'(N_WIDTH - 1);
                        dz_q       <= (divisor == '0);
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (dz_q) begin
                        quotient_q    <= '1;
                        remainder_q   <= dvd_q[D_WIDTH-1:0];
                        div_by_zero_q <= 1'b1;
                        out_valid_q   <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= quo_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            quotient_q    <= quo_d;
                            remainder_q   <= rem_d[D_WIDTH-1:0];
                            div_by_zero_q <= 1'b0;
                            out_valid_q   <= 1'b1;
                            state_q       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized checks of div_seq: latency, arithmetic, divide-by-zero,
// backpressure, mid-operation reset.
module tb_div_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] dividend;
    logic [17:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] quotient;
    logic [17:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    div_seq #(.N_WIDTH(36), .D_WIDTH(18)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand pair at a negedge, then count edges after the accept
    // edge until out_valid is seen (-1 if it never appears).
    task automatic issue(input logic [35:0] a, input logic [17:0] b, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 36'h0_DEAD_BEEF;
        divisor  = 18'h2_5A5A;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        dividend  = 36'd100;
        divisor   = 18'd7;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (quotient !== 36'd0) begin bad++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        total++; if (remainder !== 18'd0) begin bad++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_basic();
        int lat;
        issue(36'd100, 18'd7, lat);
        total++; if (lat != 36) begin bad++; $display("FAIL basic_latency got=%0d exp=36", lat); end
        total++; if (quotient !== 36'd14) begin bad++; $display("FAIL basic_quotient got=%0d exp=14", quotient); end
        total++; if (remainder !== 18'd2) begin bad++; $display("FAIL basic_remainder got=%0d exp=2", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_in_done got=%b exp=0", in_ready); end
        consume();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_after got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_out_valid_after got=%b exp=0", out_valid); end
        total++; if (quotient !== 36'd14) begin bad++; $display("FAIL basic_quotient_held got=%0d exp=14", quotient); end
    endtask

    task automatic test_boundaries();
        int lat;
        issue(36'hF_FFFF_FFFF, 18'd1, lat);
        total++; if (lat != 36) begin bad++; $display("FAIL max_div1_latency got=%0d exp=36", lat); end
        total++; if (quotient !== 36'hF_FFFF_FFFF) begin bad++; $display("FAIL max_div1_quotient got=%h exp=fffffffff", quotient); end
        total++; if (remainder !== 18'd0) begin bad++; $display("FAIL max_div1_remainder got=%h exp=0", remainder); end
        consume();
        issue(36'hF_FFFF_FFFF, 18'h3FFFF, lat);
        total++; if (quotient !== 36'h0_0004_0001) begin bad++; $display("FAIL max_divmax_quotient got=%h exp=40001", quotient); end
        total++; if (remainder !== 18'd0) begin bad++; $display("FAIL max_divmax_remainder got=%h exp=0", remainder); end
        consume();
        issue(36'd5, 18'd9, lat);
        total++; if (quotient !== 36'd0) begin bad++; $display("FAIL small_quotient got=%0d exp=0", quotient); end
        total++; if (remainder !== 18'd5) begin bad++; $display("FAIL small_remainder got=%0d exp=5", remainder); end
        consume();
        issue(36'd12345, 18'd0, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
        total++; if (quotient !== 36'hF_FFFF_FFFF) begin bad++; $display("FAIL dbz_quotient got=%h exp=fffffffff", quotient); end
        total++; if (remainder !== 18'd12345) begin bad++; $display("FAIL dbz_remainder got=%0d exp=12345", remainder); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        bit held_ok;
        bit rdy_ok;
        issue(36'd100, 18'd7, lat);
        held_ok = 1'b1;
        rdy_ok  = 1'b1;
        dividend = 36'd50;
        divisor  = 18'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || quotient !== 36'd14 || remainder !== 18'd2 || div_by_zero !== 1'b0) held_ok = 1'b0;
            if (in_ready !== 1'b0) rdy_ok = 1'b0;
        end
        total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL bp_outputs_held got=%b exp=1 (q=%0d r=%0d)", held_ok, quotient, remainder); end
        total++; if (rdy_ok !== 1'b1) begin bad++; $display("FAIL bp_in_ready_low got=%b exp=1", rdy_ok); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_release got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_out_valid_release got=%b exp=0", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat != 36) begin bad++; $display("FAIL bp_new_latency got=%0d exp=36", lat); end
        total++; if (quotient !== 36'd10) begin bad++; $display("FAIL bp_new_quotient got=%0d exp=10", quotient); end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        dividend = 36'd987654321;
        divisor  = 18'd1000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); end
        total++; if (quotient !== 36'd0) begin bad++; $display("FAIL mid_rst_quotient got=%h exp=0", quotient); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_stale_valid got=%b exp=0", out_valid); end
        issue(36'd100, 18'd7, lat);
        total++; if (lat != 36) begin bad++; $display("FAIL mid_rst_latency got=%0d exp=36", lat); end
        total++; if (quotient !== 36'd14) begin bad++; $display("FAIL mid_rst_quotient_after got=%0d exp=14", quotient); end
        total++; if (remainder !== 18'd2) begin bad++; $display("FAIL mid_rst_remainder_after got=%0d exp=2", remainder); end
        consume();
    endtask

    task automatic test_random();
        int lat;
        int results;
        int accepts;
        int unsigned rv;
        logic [35:0] a;
        logic [17:0] b;
        logic [35:0] eq;
        logic [17:0] er;
        logic        ez;
        results = 0;
        accepts = 0;
        for (int i = 0; i < 400; i++) begin
            a  = {$urandom, $urandom};
            rv = $urandom;
            b  = rv[17:0];
            if (rv[20]) b = b >> $urandom_range(17, 0);
            if ($urandom_range(9, 0) == 0) b = 18'd0;
            if (b == 18'd0) begin
                eq = '1;
                er = a[17:0];
                ez = 1'b1;
            end else begin
                eq = a / {18'd0, b};
                er = 18'(a % {18'd0, b});
                ez = 1'b0;
            end
            issue(a, b, lat);
            accepts++;
            if (lat >= 0) results++;
            total++;
            if (quotient !== eq || remainder !== er || div_by_zero !== ez || lat < 0) begin
                bad++;
                $display("FAIL rand_%0d a=%h b=%h got q=%h r=%h z=%b lat=%0d exp q=%h r=%h z=%b", i, a, b, quotient, remainder, div_by_zero, lat, eq, er, ez);
            end
            repeat ($urandom_range(3, 0)) @(negedge clk);
            consume();
        end
        total++; if (results != accepts) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", results, accepts); end
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        rst_n     = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
